// File: rtl/bram_fifo_v2_pkg.sv
// Shared helpers for the bram_fifo_v2 slice: pointer/count widths and the
// elaboration-time parameter legality check.
package bram_fifo_pkg;

    // Smallest legal depth; anything shallower makes the flag logic degenerate.
    localparam int unsigned MinDepth = 4;

    // Pointers carry one extra wrap bit above the memory address.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Count must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_ok(input int unsigned depth,
                                     input int unsigned af_thresh,
                                     input int unsigned ae_thresh);
        return is_pow2(depth) && (depth >= MinDepth) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/bram_fifo_v2_if.sv
// Handshake and status bundle for bram_fifo_v2. The master side is the
// producer/consumer, the slave side is the FIFO itself.
interface bram_fifo_v2_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DWIDTH = 16
);
    localparam int unsigned CW = bram_fifo_pkg::cnt_w(DEPTH);

    logic              flush;
    logic              wr_en;
    logic [DWIDTH-1:0] din;
    logic              rd_en;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );

endinterface

// File: rtl/bram_sdp.sv
// Simple dual-port memory: one write port, one read port with a 1-cycle
// registered read. The read register holds when no read is issued and has a
// synchronous clear so the FIFO output never shows stale data after reset.
module bram_sdp #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DWIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DWIDTH-1:0]          wdata_i,
    input  logic                       re_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    input  logic                       clr_i,
    output logic [DWIDTH-1:0]          rdata_o
);
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q, rdata_d;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register next state: clear wins, otherwise load on read, else hold.
    always_comb begin
        rdata_d = rdata_q;
        if (clr_i) begin
            rdata_d = '0;
        end else if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Read register.
    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_fifo_v2.sv
// Synchronous FIFO on a simple dual-port BRAM with count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
// Define BRAM_FIFO_FWFT_EN for first-word-fall-through operation; otherwise
// dout updates one edge after an accepted read and dout_valid pulses.
module bram_fifo_v2
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input logic           clk,
    input logic           rstn,
    bram_fifo_v2_if.slave fifo
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("bram_fifo_v2: DEPTH must be a power of two >= 4 and thresholds in range");
    end

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              dout_valid_q, dout_valid_d;
    logic              full, empty;
    logic              wr_acc, rd_acc, rd_issue, run;
    logic [DWIDTH-1:0] mem_rdata;

    // Reset or flush stops all memory activity in that cycle.
    assign run    = rstn && !fifo.flush;
    assign full   = (count_q == DepthC);
    assign wr_acc = fifo.wr_en && !full;
    assign rd_acc = fifo.rd_en && !empty;

`ifdef BRAM_FIFO_FWFT_EN
    // Pipeline: memory -> BRAM read register (mid) -> output register.
    logic              mid_valid_q, mid_valid_d;
    logic              mid_move, mem_nonempty;
    logic [DWIDTH-1:0] dout_q, dout_d;

    assign empty        = !dout_valid_q;
    assign mem_nonempty = (wptr_q != rptr_q);
    assign mid_move     = mid_valid_q && (!dout_valid_q || rd_acc);
    // Prefetch whenever the mid stage is, or is about to become, free.
    assign rd_issue     = mem_nonempty && (!mid_valid_q || mid_move);
`else
    assign empty    = (count_q == '0);
    assign rd_issue = rd_acc;
`endif

    bram_sdp #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (run && wr_acc),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (fifo.din),
        .re_i    (run && rd_issue),
        .raddr_i (rptr_q[AW-1:0]),
        .clr_i   (!run),
        .rdata_o (mem_rdata)
    );

    // Next state for pointers, count, flags and output stage.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        udf_d        = udf_q;
        dout_valid_d = dout_valid_q;
`ifdef BRAM_FIFO_FWFT_EN
        mid_valid_d  = mid_valid_q;
        dout_d       = dout_q;
`endif
        if (!run) begin
            wptr_d       = '0;
            rptr_d       = '0;
            count_d      = '0;
            ovf_d        = 1'b0;
            udf_d        = 1'b0;
            dout_valid_d = 1'b0;
`ifdef BRAM_FIFO_FWFT_EN
            mid_valid_d  = 1'b0;
            dout_d       = '0;
`endif
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (rd_issue) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (fifo.wr_en && full) begin
                ovf_d = 1'b1;
            end
            if (fifo.rd_en && empty) begin
                udf_d = 1'b1;
            end
`ifdef BRAM_FIFO_FWFT_EN
            if (rd_issue) begin
                mid_valid_d = 1'b1;
            end else if (mid_move) begin
                mid_valid_d = 1'b0;
            end
            if (mid_move) begin
                dout_d       = mem_rdata;
                dout_valid_d = 1'b1;
            end else if (rd_acc) begin
                dout_valid_d = 1'b0;
            end
`else
            dout_valid_d = rd_acc;
`endif
        end
    end

    // State registers; reset is folded into the next-state logic.
    always_ff @(posedge clk) begin
        wptr_q       <= wptr_d;
        rptr_q       <= rptr_d;
        count_q      <= count_d;
        ovf_q        <= ovf_d;
        udf_q        <= udf_d;
        dout_valid_q <= dout_valid_d;
`ifdef BRAM_FIFO_FWFT_EN
        mid_valid_q  <= mid_valid_d;
        dout_q       <= dout_d;
`endif
    end

`ifdef BRAM_FIFO_FWFT_EN
    assign fifo.dout = dout_q;
`else
    assign fifo.dout = mem_rdata;
`endif
    assign fifo.dout_valid   = dout_valid_q;
    assign fifo.full         = full;
    assign fifo.empty        = empty;
    assign fifo.almost_full  = (count_q >= AfC);
    assign fifo.almost_empty = (count_q <= AeC);
    assign fifo.count        = count_q;
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = udf_q;

endmodule

// File: tb/tb_bram_fifo_v2.sv
// Directed bench for bram_fifo_v2 with DEPTH=8, DWIDTH=16, AF_THRESH=6,
// AE_THRESH=2. Standard-mode vectors by default; FWFT vectors when
// BRAM_FIFO_FWFT_EN is defined.
module tb_bram_fifo_v2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int checks = 0;
    int errors = 0;

    bram_fifo_v2_if #(.DEPTH(8), .DWIDTH(16)) f ();

    bram_fifo_v2 #(
        .DEPTH     (8),
        .DWIDTH    (16),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .fifo (f)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample point: 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        f.wr_en = 1'b1;
        f.din   = d;
        step();
        f.wr_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        f.rd_en = 1'b1;
        step();
        f.rd_en = 1'b0;
        check(tag, 32'(f.dout), 32'(exp));
        check({tag, "_dv"}, 32'(f.dout_valid), 32'd1);
    endtask

    initial begin
        int maxc;
        f.flush = 1'b0;
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        f.din   = '0;

        // Reset state
        f.wr_en = 1'b1;
        f.din   = 16'h9999;
        step();
        step();
        f.wr_en = 1'b0;
        check("rst_empty", 32'(f.empty), 32'd1);
        check("rst_full", 32'(f.full), 32'd0);
        check("rst_ae", 32'(f.almost_empty), 32'd1);
        check("rst_af", 32'(f.almost_full), 32'd0);
        check("rst_count", 32'(f.count), 32'd0);
        check("rst_dout", 32'(f.dout), 32'd0);
        check("rst_dv", 32'(f.dout_valid), 32'd0);
        check("rst_ovf", 32'(f.overflow), 32'd0);
        check("rst_udf", 32'(f.underflow), 32'd0);
        rstn = 1'b1;
        step();

`ifdef BRAM_FIFO_FWFT_EN
        // Write at edge T; word visible after T+2
        push(16'h1234);
        check("fwft_dv_t", 32'(f.dout_valid), 32'd0);
        step();
        check("fwft_dv_t1", 32'(f.dout_valid), 32'd0);
        step();
        check("fwft_dv_t2", 32'(f.dout_valid), 32'd1);
        check("fwft_dout_t2", 32'(f.dout), 32'h1234);
        check("fwft_empty", 32'(f.empty), 32'd0);
        check("fwft_count1", 32'(f.count), 32'd1);
        push(16'h0002);
        push(16'h0003);
        step();
        step();
        check("fwft_count3", 32'(f.count), 32'd3);
        check("fwft_head", 32'(f.dout), 32'h1234);
        // Three back-to-back pops
        f.rd_en = 1'b1;
        step();
        check("fwft_pop1", 32'(f.dout), 32'h0002);
        check("fwft_pop1_dv", 32'(f.dout_valid), 32'd1);
        step();
        check("fwft_pop2", 32'(f.dout), 32'h0003);
        check("fwft_pop2_dv", 32'(f.dout_valid), 32'd1);
        step();
        f.rd_en = 1'b0;
        check("fwft_pop3_dv", 32'(f.dout_valid), 32'd0);
        check("fwft_pop3_empty", 32'(f.empty), 32'd1);
        check("fwft_pop3_count", 32'(f.count), 32'd0);
        check("fwft_udf", 32'(f.underflow), 32'd0);
`else
        // Fill with threshold checks along the way
        for (int i = 1; i <= 8; i++) begin
            push(16'(i));
            case (i)
                2: begin
                    check("thr2_ae", 32'(f.almost_empty), 32'd1);
                    check("thr2_af", 32'(f.almost_full), 32'd0);
                end
                3: begin
                    check("thr3_ae", 32'(f.almost_empty), 32'd0);
                    check("thr3_af", 32'(f.almost_full), 32'd0);
                end
                5: begin
                    check("thr5_ae", 32'(f.almost_empty), 32'd0);
                    check("thr5_af", 32'(f.almost_full), 32'd0);
                end
                6: begin
                    check("thr6_ae", 32'(f.almost_empty), 32'd0);
                    check("thr6_af", 32'(f.almost_full), 32'd1);
                end
                default: ;
            endcase
        end
        check("fill_full", 32'(f.full), 32'd1);
        check("fill_count", 32'(f.count), 32'd8);
        check("fill_ovf0", 32'(f.overflow), 32'd0);
        push(16'hFFFF);
        check("ovf_set", 32'(f.overflow), 32'd1);
        check("ovf_count", 32'(f.count), 32'd8);

        // Read+write while full: read only
        f.wr_en = 1'b1;
        f.rd_en = 1'b1;
        f.din   = 16'h5555;
        step();
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        check("rw_full_count", 32'(f.count), 32'd7);
        check("rw_full_dout", 32'(f.dout), 32'h0001);
        check("rw_full_dv", 32'(f.dout_valid), 32'd1);
        check("rw_full_full", 32'(f.full), 32'd0);
        step();
        check("dv_pulse", 32'(f.dout_valid), 32'd0);
        check("dout_hold", 32'(f.dout), 32'h0001);

        for (int i = 2; i <= 8; i++) begin
            pop_chk($sformatf("drain%0d", i), 16'(i));
        end
        check("drain_empty", 32'(f.empty), 32'd1);
        check("drain_count", 32'(f.count), 32'd0);
        check("drain_udf0", 32'(f.underflow), 32'd0);

        // Read+write while empty: write only
        f.wr_en = 1'b1;
        f.rd_en = 1'b1;
        f.din   = 16'h7777;
        step();
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        check("rw_empty_count", 32'(f.count), 32'd1);
        check("rw_empty_udf", 32'(f.underflow), 32'd1);
        check("rw_empty_dv", 32'(f.dout_valid), 32'd0);
        pop_chk("rw_empty_rd", 16'h7777);

        // Interleaved pairs drive pointers past 2*DEPTH
        maxc = 0;
        for (int i = 0; i < 20; i++) begin
            push(16'h0100 + 16'(i));
            if (int'(f.count) > maxc) maxc = int'(f.count);
            pop_chk($sformatf("wrap%0d", i), 16'h0100 + 16'(i));
        end
        check("wrap_maxcount", 32'(maxc), 32'd1);
        check("wrap_empty", 32'(f.empty), 32'd1);

        // Flush at count=5 with overflow still set
        for (int i = 0; i < 5; i++) begin
            push(16'h0A00 + 16'(i));
        end
        check("pre_flush_count", 32'(f.count), 32'd5);
        check("pre_flush_ovf", 32'(f.overflow), 32'd1);
        f.flush = 1'b1;
        f.wr_en = 1'b1;
        f.rd_en = 1'b1;
        f.din   = 16'hDEAD;
        step();
        f.flush = 1'b0;
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        check("flush_count", 32'(f.count), 32'd0);
        check("flush_empty", 32'(f.empty), 32'd1);
        check("flush_ovf", 32'(f.overflow), 32'd0);
        check("flush_udf", 32'(f.underflow), 32'd0);
        check("flush_dout", 32'(f.dout), 32'd0);
        check("flush_dv", 32'(f.dout_valid), 32'd0);
        push(16'hABCD);
        pop_chk("post_flush", 16'hABCD);

        // Reset mid-operation discards contents and same-cycle write
        push(16'h0C00);
        push(16'h0C01);
        push(16'h0C02);
        rstn    = 1'b0;
        f.wr_en = 1'b1;
        f.din   = 16'hBEEF;
        step();
        rstn    = 1'b1;
        f.wr_en = 1'b0;
        check("midrst_count", 32'(f.count), 32'd0);
        check("midrst_empty", 32'(f.empty), 32'd1);
        check("midrst_dout", 32'(f.dout), 32'd0);
        push(16'h4242);
        pop_chk("post_rst", 16'h4242);
        check("post_rst_count", 32'(f.count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_fifo_v2.md
BRAM_FIFO_V2 -- requirements
Module: bram_fifo_v2

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=4).
REQ-002 SHALL have parameter DWIDTH, default 16, data width in bits.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL use clock clk and reset rstn, where reset rstn is synchronous and active-low, on clock clk.
REQ-006 SHALL have ports (name direction width meaning):
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- flush  in  1  synchronous clear
- wr_en  in  1  write request
- din  in  DWIDTH  write data
- rd_en  in  1  read request (pop in FWFT mode)
- dout  out  DWIDTH  read data
- dout_valid  out  1  dout holds a valid word
- full  out  1  no write accepted
- empty  out  1  no read accepted
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  $clog2(DEPTH)+1  words held, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Function
REQ-007 SHALL accept a write iff wr_en && !full, and a read iff rd_en && !empty; full/empty are evaluated on registered state at that edge.
REQ-008 SHALL use AW+1-bit read/write pointers (AW = $clog2(DEPTH)) that wrap modulo 2*DEPTH; memory is addressed by the low AW bits.
REQ-009 SHALL hold count = words stored, +1 per accepted write, -1 per accepted read, unchanged on simultaneous accepted read and write.
REQ-010 SHALL assert full iff count==DEPTH and empty iff no word is readable; almost_full/almost_empty are derived combinationally from registered count.
REQ-011 SHALL, when full, reject a write even if a read is accepted in the same cycle; when empty, reject the read while accepting the write.
REQ-012 SHALL, in standard mode, update dout and pulse dout_valid for one cycle on the edge after an accepted read; otherwise dout holds its value.
REQ-013 SHALL set overflow on wr_en && full and underflow on rd_en && empty; both stay set until reset or flush.
REQ-014 SHALL, on flush, clear pointers, count, dout, dout_valid, overflow and underflow at the next edge; flush has priority over same-cycle wr_en/rd_en, which are discarded and not flagged.
REQ-015 SHALL leave memory contents undefined after reset or flush; no read returns stale data.

Reset
REQ-016 SHALL, while rstn is low at a clk edge, drive: empty=1, full=0, almost_empty=1, almost_full=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0.
REQ-017 SHALL, on reset mid-operation, discard all stored words and ignore wr_en/rd_en in that cycle.

Configuration
REQ-018 SHALL support macro BRAM_FIFO_FWFT_EN. When undefined, the FIFO runs in standard mode per REQ-012.
REQ-019 SHALL, with BRAM_FIFO_FWFT_EN defined, operate first-word-fall-through:
- a prefetch output register presents the head word on dout with dout_valid=1 and empty=!dout_valid
- rd_en pops the presented word
- a write to an empty FIFO at edge T gives dout_valid=1 after edge T+2
- back-to-back pops sustain one word per cycle
- count includes the output register
- capacity remains DEPTH

Structure
REQ-020 SHALL place the parameter-check function and the shared pointer/count width helpers in package bram_fifo_pkg.
REQ-021 SHALL instantiate one sub-module bram_sdp: simple dual-port memory with one write port, one read port, and 1-cycle registered read.
REQ-022 SHALL fail elaboration if DEPTH is not a power of two >=4, or if AF_THRESH/AE_THRESH are out of range.

Verification (DEPTH=8, DWIDTH=16)
REQ-023 SHALL cover fill/drain: write 0x0001..0x0008, then a 9th write of 0xFFFF -> full=1, count=8, overflow=1, 0xFFFF dropped; 8 reads return 0x0001..0x0008 in order, then empty=1.
REQ-024 SHALL cover simultaneous read and write at count=8 -> read accepted, write rejected, count=7; at count=0 -> write accepted, read rejected, underflow=1, count=1.
REQ-025 SHALL cover thresholds with AF_THRESH=6, AE_THRESH=2: counts 2/3/5/6 -> almost_empty 1/0/0/0, almost_full 0/0/0/1.
REQ-026 SHALL cover wrap-around: 20 interleaved write/read pairs of 0x0100+i -> data in order, count never >1, pointers wrap past 2*DEPTH.
REQ-027 SHALL cover flush at count=5 with overflow=1 -> next edge count=0, empty=1, overflow=0; a subsequent write of 0xABCD reads back 0xABCD.
REQ-028 SHALL cover FWFT (macro defined): write 0x1234 at edge T -> dout=0x1234 and dout_valid=1 after T+2; rd_en high for 3 cycles over 3 stored words pops all 3 with no bubble.
